wb_elastic_buffer: RTL



---
 rtl/wb_elastic_buffer_if.sv | 38 +++
 rtl/wb_elastic_buffer.sv | 111 +++++++++++
 2 files changed

// File: rtl/wb_elastic_buffer_if.sv
// Handshake and payload bundle between the pipeline stage feeding the
// writeback elastic buffer (master) and the buffer itself (slave).
interface wb_elastic_buffer_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // Upstream side
    logic              in_valid;
    logic              in_ready;
    logic              regwrite_in;
    logic              memtoreg_in;
    logic [DATA_W-1:0] memres_in;
    logic [DATA_W-1:0] alures_in;
    logic [REG_W-1:0]  writeregister_in;

    // Downstream side
    logic              out_valid;
    logic              out_ready;
    logic              regwrite_out;
    logic              memtoreg_out;
    logic [DATA_W-1:0] memres_out;
    logic [DATA_W-1:0] alures_out;
    logic [REG_W-1:0]  writeregister_out;

    modport master (
        output in_valid, regwrite_in, memtoreg_in, memres_in, alures_in,
               writeregister_in, out_ready,
        input  in_ready, out_valid, regwrite_out, memtoreg_out, memres_out,
               alures_out, writeregister_out
    );

    modport slave (
        input  in_valid, regwrite_in, memtoreg_in, memres_in, alures_in,
               writeregister_in, out_ready,
        output in_ready, out_valid, regwrite_out, memtoreg_out, memres_out,
               alures_out, writeregister_out
    );
endinterface

// File: rtl/wb_elastic_buffer.sv
// Elastic FIFO between MEM and WB: decouples stage stalls, gates control
// bits with valid so bubbles never write the register file.
module wb_elastic_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    wb_elastic_buffer_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           stall_cycles
);
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] memres;
        logic [DATA_W-1:0] alures;
        logic [REG_W-1:0]  writeregister;
    } entry_t;

    entry_t              store [DEPTH];
    entry_t              head;
    entry_t              in_entry;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_BITS-1:0] occ;
    logic [CNT_W-1:0]    stall_q;
    logic                can_push;
    logic                has_head;
    logic                push;
    logic                pop;

    // Ready/valid depend only on the registered occupancy, never on out_ready.
    always_comb begin
        can_push = (occ < FULL_COUNT);
        has_head = (occ != '0);
        push     = bus.in_valid && can_push && !flush;
        pop      = has_head && bus.out_ready && !flush;
    end

    always_comb begin
        in_entry.regwrite      = bus.regwrite_in;
        in_entry.memtoreg      = bus.memtoreg_in;
        in_entry.memres        = bus.memres_in;
        in_entry.alures        = bus.alures_in;
        in_entry.writeregister = bus.writeregister_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_BITS'(1);
                2'b01:   occ <= occ - CNT_BITS'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Entries keep their contents across pops and flushes; only push writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (push) begin
            store[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (bus.in_valid && !can_push && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    always_comb begin
        head                  = store[rd_ptr];
        bus.in_ready          = can_push;
        bus.out_valid         = has_head;
        bus.regwrite_out      = has_head && head.regwrite;
        bus.memtoreg_out      = has_head && head.memtoreg;
        bus.memres_out        = head.memres;
        bus.alures_out        = head.alures;
        bus.writeregister_out = head.writeregister;
        count                 = occ;
        stall_cycles          = stall_q;
    end
endmodule
